spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

SPI slave endpoint that receives the 16-bit programming stream driven by the programmer's SPI master (SCK/MOSI/NSS), pushes every complete word into a downstream 16-bit FIFO and returns a status word on MISO. It sits on the target side of the link, between the SPI pins and the IAP image buffer, clocked by the 100 MHz system clock. SCK, MOSI and NSS are oversampled and are not used as clocks.

## Interface
Parameters:
- WORD_W, 16, bits per SPI word; MSB first.
- SYNC_STAGES, 2, synchronizer depth on SCK/MOSI/NSS (≥2).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  asynchronous, active-high reset.
- SCK  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); at most sys_clk/8.
- MOSI  in  1  serial data from the master.
- NSS  in  1  active-low frame select.
- MISO  out  1  serial data to the master.
- fifo_full  in  1  downstream FIFO full.
- fifo_wr_req  out  1  one-cycle write strobe.
- fifo_wr_data  out  WORD_W  received word, valid while fifo_wr_req=1.
- tx_data  in  WORD_W  status word to return; sampled at each word load.
- err_clr  in  1  one-cycle pulse; clears the sticky errors.
- frame_active  out  1  high while a frame is open (state ACTIVE).
- word_cnt  out  16  words completed in the current or last frame; saturates at 0xFFFF.
- overflow_err  out  1  sticky: a word completed while fifo_full=1.
- frame_err  out  1  sticky: NSS rose with a partial word pending.

## Operation
- Input path: SCK, MOSI and NSS each pass through SYNC_STAGES flops, then one history flop for edge detection. All three inputs see equal latency.
- FSM states: IDLE and ACTIVE.
  - IDLE → ACTIVE on a synchronized NSS fall. On that transition:
    - bit_cnt=0
    - word_cnt=0
    - tx shift register loaded (see Configuration)
    - MISO = tx MSB
  - ACTIVE → IDLE on a synchronized NSS rise. If bit_cnt≠0, set frame_err and discard the partial word.
- SCK rising edge in ACTIVE: shift synchronized MOSI into rx_shift LSB and increment bit_cnt.
  - When bit_cnt reaches WORD_W, bit_cnt wraps to 0 and a word is complete.
- Word complete:
  - fifo_full=0: fifo_wr_req=1 for exactly one cycle, fifo_wr_data=rx word, word_cnt+1.
  - fifo_full=1: no write, the word is dropped, overflow_err=1, word_cnt still +1.
- SCK falling edge in ACTIVE: shift tx left and drive the new MSB on MISO.
  - If the preceding rising edge completed a word, reload tx instead of shifting and drive its MSB.
- IDLE: MISO=0, and SCK edges are ignored.
- Sticky errors clear only on err_clr.
  - err_clr in the same cycle as a new error event: the error wins (flag stays 1).
- Reset mid-frame: everything returns to reset values. No FIFO write for the partial word. The next frame requires a fresh NSS fall.
- Reset values: MISO=0, fifo_wr_req=0, fifo_wr_data=0, frame_active=0, word_cnt=0, overflow_err=0, frame_err=0, FSM=IDLE.

## Timing
- Input-to-internal edge latency: SYNC_STAGES+1 sys_clk cycles.
- fifo_wr_req asserts on the sys_clk cycle after the internal detection of the 16th rising edge.
  - Total: SYNC_STAGES+2 cycles after the pin edge.
- MISO updates SYNC_STAGES+2 cycles after the pin falling edge of SCK. At SCK ≤ sys_clk/8 this settles before the next master rising edge.
- Master requirements:
  - ≥4 sys_clk between NSS fall and the first SCK rise.
  - ≥4 sys_clk between the last SCK fall and NSS rise.
- fifo_full is sampled in the cycle the word completes, with no lookahead.
- Back-to-back words need no gap. Sustained throughput is one word per 16 SCK periods.

## Configuration
- SPI_SLAVE_ECHO_EN defined: at each word load the tx shift register loads the last received word instead of tx_data.
  - The first word of a frame returns 0x0000.
  - The master reads back word N−1 while sending word N, for loopback link checks.
- SPI_SLAVE_ECHO_EN undefined: every load takes tx_data as sampled in the load cycle.

## Test plan
- Frame of 0xA5C3, 0x0F0F at SCK=12.5 MHz, fifo_full=0 → two fifo_wr_req pulses with 0xA5C3 then 0x0F0F; word_cnt=2; both errors 0.
- tx_data=0x8001 held, macro undefined, one-word frame → master captures 0x8001 on MISO.
- SPI_SLAVE_ECHO_EN defined; send 0x1234, 0x5678, 0x9ABC → master receives 0x0000, 0x1234, 0x5678.
- fifo_full=1 during the second of three words 0x1111/0x2222/0x3333 → only 0x1111 and 0x3333 written; overflow_err=1; word_cnt=3; err_clr pulse → overflow_err=0.
- NSS rises after 9 bits → no fifo write; frame_err=1; frame_active=0. Next full frame with 0xBEEF → 0xBEEF written, frame_err stays 1.
- sys_rst asserted after 8 bits of a word → all outputs reset immediately. After release, a new frame with 0x00FF → exactly one write of 0x00FF.

Source files
------------

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
//
// SPI mode-0 slave receiver for the 16-bit programming stream. SCK, MOSI and
// NSS are oversampled on sys_clk; they are never used as clocks. Every
// completed word is pushed into the downstream FIFO. A status word is shifted
// back to the master on MISO.
//
// Optional feature (compile-time macro):
//   SPI_SLAVE_ECHO_EN : when defined, each word load takes the last received
//                       word instead of tx_data. The first word of a frame
//                       returns zero, so the master reads word N-1 while it
//                       sends word N.
//
// Parameters:
//   WORD_W      bits per SPI word, MSB first
//   SYNC_STAGES synchronizer depth on SCK/MOSI/NSS (>= 2)
//
// Ports:
//   sys_clk, sys_rst  system clock, asynchronous active-high reset
//   SCK, MOSI, NSS    SPI pins from the master (NSS active low)
//   MISO              serial status data to the master
//   fifo_full         downstream FIFO full, sampled when a word completes
//   fifo_wr_req       one-cycle write strobe
//   fifo_wr_data      received word, valid while fifo_wr_req is high
//   tx_data           status word, sampled at each word load
//   err_clr           one-cycle pulse that clears the sticky errors
//   frame_active      high while a frame is open
//   word_cnt          words completed in the current or last frame (saturating)
//   overflow_err      sticky: a word completed while fifo_full was high
//   frame_err         sticky: NSS rose with a partial word pending
// -----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              NSS,
  output logic              MISO,
  input  logic              fifo_full,
  output logic              fifo_wr_req,
  output logic [WORD_W-1:0] fifo_wr_data,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              err_clr,
  output logic              frame_active,
  output logic [15:0]       word_cnt,
  output logic              overflow_err,
  output logic              frame_err
);

  localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] BIT_ZERO = {CNT_W{1'b0}};
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Synchronizers, history flops and registered edge pulses
  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] nss_sync_r;
  logic                   sck_hist_r;
  logic                   nss_hist_r;
  logic                   mosi_hist_r;
  logic                   sck_rise_r;
  logic                   sck_fall_r;
  logic                   nss_rise_r;
  logic                   nss_fall_r;

  // Frame state
  state_t                 state_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [WORD_W-1:0]      rx_shift_r;
  logic [WORD_W-1:0]      tx_shift_r;
  logic [WORD_W-1:0]      echo_r;
  logic                   reload_pending_r;
  logic                   miso_r;
  logic                   fifo_wr_req_r;
  logic [WORD_W-1:0]      fifo_wr_data_r;
  logic                   frame_active_r;
  logic [15:0]            word_cnt_r;
  logic                   overflow_err_r;
  logic                   frame_err_r;

  // Decoded events
  logic [WORD_W-1:0]      rx_word_s;
  logic [WORD_W-1:0]      frame_load_s;
  logic [WORD_W-1:0]      word_load_s;
  logic                   word_done_s;
  logic                   overflow_set_s;
  logic                   frame_err_set_s;

  // Synchronize the pins and register edge pulses; MOSI is delayed through its
  // own history flop so the data bit lines up with the registered SCK edge.
  // Everything resets to 0: an NSS that is already low when reset releases
  // shows no fall, so a new frame always needs a real high-to-low transition.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      nss_sync_r  <= {SYNC_STAGES{1'b0}};
      sck_hist_r  <= 1'b0;
      nss_hist_r  <= 1'b0;
      mosi_hist_r <= 1'b0;
      sck_rise_r  <= 1'b0;
      sck_fall_r  <= 1'b0;
      nss_rise_r  <= 1'b0;
      nss_fall_r  <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], SCK};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      nss_sync_r  <= {nss_sync_r[SYNC_STAGES-2:0], NSS};
      sck_hist_r  <= sck_sync_r[SYNC_STAGES-1];
      nss_hist_r  <= nss_sync_r[SYNC_STAGES-1];
      mosi_hist_r <= mosi_sync_r[SYNC_STAGES-1];
      sck_rise_r  <= sck_sync_r[SYNC_STAGES-1] & ~sck_hist_r;
      sck_fall_r  <= ~sck_sync_r[SYNC_STAGES-1] & sck_hist_r;
      nss_rise_r  <= nss_sync_r[SYNC_STAGES-1] & ~nss_hist_r;
      nss_fall_r  <= ~nss_sync_r[SYNC_STAGES-1] & nss_hist_r;
    end
  end

  // Select the value loaded into the tx shifter at frame start and word end
  always_comb begin
    rx_word_s = {rx_shift_r[WORD_W-2:0], mosi_hist_r};
`ifdef SPI_SLAVE_ECHO_EN
    frame_load_s = {WORD_W{1'b0}};
    word_load_s  = echo_r;
`else
    frame_load_s = tx_data;
    word_load_s  = tx_data;
`endif
  end

  // Decode word completion and error events for the sticky flags
  always_comb begin
    word_done_s     = 1'b0;
    frame_err_set_s = 1'b0;
    case (state_r)
      ST_ACTIVE: begin
        word_done_s     = ~nss_rise_r & sck_rise_r & (bit_cnt_r == BIT_LAST);
        frame_err_set_s = nss_rise_r & (bit_cnt_r != BIT_ZERO);
      end
      default: begin
        word_done_s     = 1'b0;
        frame_err_set_s = 1'b0;
      end
    endcase
    overflow_set_s = word_done_s & fifo_full;
  end

  // Frame FSM: bit counting, rx/tx shifting, FIFO writes and MISO drive
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r          <= ST_IDLE;
      bit_cnt_r        <= BIT_ZERO;
      rx_shift_r       <= {WORD_W{1'b0}};
      tx_shift_r       <= {WORD_W{1'b0}};
      echo_r           <= {WORD_W{1'b0}};
      reload_pending_r <= 1'b0;
      miso_r           <= 1'b0;
      fifo_wr_req_r    <= 1'b0;
      fifo_wr_data_r   <= {WORD_W{1'b0}};
      frame_active_r   <= 1'b0;
      word_cnt_r       <= 16'h0000;
    end else begin
      fifo_wr_req_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          miso_r <= 1'b0;
          if (nss_fall_r) begin
            state_r          <= ST_ACTIVE;
            frame_active_r   <= 1'b1;
            bit_cnt_r        <= BIT_ZERO;
            word_cnt_r       <= 16'h0000;
            echo_r           <= {WORD_W{1'b0}};
            reload_pending_r <= 1'b0;
            tx_shift_r       <= frame_load_s;
            miso_r           <= frame_load_s[WORD_W-1];
          end
        end
        ST_ACTIVE: begin
          if (nss_rise_r) begin
            // Any partial word is simply abandoned here.
            state_r          <= ST_IDLE;
            frame_active_r   <= 1'b0;
            bit_cnt_r        <= BIT_ZERO;
            reload_pending_r <= 1'b0;
            miso_r           <= 1'b0;
          end else begin
            if (sck_rise_r) begin
              rx_shift_r <= rx_word_s;
              if (bit_cnt_r == BIT_LAST) begin
                bit_cnt_r        <= BIT_ZERO;
                reload_pending_r <= 1'b1;
                echo_r           <= rx_word_s;
                if (word_cnt_r != CNT_MAX) begin
                  word_cnt_r <= word_cnt_r + 16'd1;
                end
                if (!fifo_full) begin
                  fifo_wr_req_r  <= 1'b1;
                  fifo_wr_data_r <= rx_word_s;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end
            // The falling edge after a completed word starts the next tx word.
            if (sck_fall_r) begin
              if (reload_pending_r) begin
                reload_pending_r <= 1'b0;
                tx_shift_r       <= word_load_s;
                miso_r           <= word_load_s[WORD_W-1];
              end else begin
                tx_shift_r <= {tx_shift_r[WORD_W-2:0], 1'b0};
                miso_r     <= tx_shift_r[WORD_W-2];
              end
            end
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          frame_active_r <= 1'b0;
          miso_r         <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr wins
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      overflow_err_r <= 1'b0;
      frame_err_r    <= 1'b0;
    end else begin
      if (overflow_set_s) begin
        overflow_err_r <= 1'b1;
      end else if (err_clr) begin
        overflow_err_r <= 1'b0;
      end else begin
        overflow_err_r <= overflow_err_r;
      end
      if (frame_err_set_s) begin
        frame_err_r <= 1'b1;
      end else if (err_clr) begin
        frame_err_r <= 1'b0;
      end else begin
        frame_err_r <= frame_err_r;
      end
    end
  end

  assign MISO         = miso_r;
  assign fifo_wr_req  = fifo_wr_req_r;
  assign fifo_wr_data = fifo_wr_data_r;
  assign frame_active = frame_active_r;
  assign word_cnt     = word_cnt_r;
  assign overflow_err = overflow_err_r;
  assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
//
// Self-checking bench for spi_slave_rx. A mode-0 SPI master (SCK = sys_clk/8)
// drives directed frames followed by randomized ones. Expected FIFO writes,
// word counts, sticky errors and the MISO words are derived from frame-level
// rules in a small reference model.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        SCK;
  logic        MOSI;
  logic        NSS;
  logic        MISO;
  logic        fifo_full;
  logic        fifo_wr_req;
  logic [15:0] fifo_wr_data;
  logic [15:0] tx_data;
  logic        err_clr;
  logic        frame_active;
  logic [15:0] word_cnt;
  logic        overflow_err;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          mdl_cnt;
  logic        mdl_ovf;
  logic        mdl_ferr;

  // Per-frame stimulus
  logic [15:0] w_arr[8];
  logic        f_arr[8];

  spi_slave_rx #(.WORD_W(16), .SYNC_STAGES(2)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .SCK          (SCK),
    .MOSI         (MOSI),
    .NSS          (NSS),
    .MISO         (MISO),
    .fifo_full    (fifo_full),
    .fifo_wr_req  (fifo_wr_req),
    .fifo_wr_data (fifo_wr_data),
    .tx_data      (tx_data),
    .err_clr      (err_clr),
    .frame_active (frame_active),
    .word_cnt     (word_cnt),
    .overflow_err (overflow_err),
    .frame_err    (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Collect every FIFO write, sampled away from the active edge
  always @(negedge sys_clk) begin
    if (fifo_wr_req === 1'b1) got_q.push_back(fifo_wr_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One SPI bit: MOSI set in the low phase, MISO captured at the rising edge
  task automatic send_bit(input logic b, output logic m);
    MOSI = b;
    clk_n(4);
    m = MISO;
    SCK = 1'b1;
    clk_n(4);
    SCK = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_wdata"}, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_active"}, frame_active, 1'b0);
    chk({tag, "_miso_idle"}, MISO, 1'b0);
    chk({tag, "_word_cnt"}, word_cnt, mdl_cnt);
    chk({tag, "_ovf"}, overflow_err, mdl_ovf);
    chk({tag, "_ferr"}, frame_err, mdl_ferr);
    compare_writes(tag);
  endtask

  // Full frame: nw complete words from w_arr, then 'part' bits of w_arr[nw]
  task automatic run_frame(input string tag, input int nw, input int part, input logic [15:0] txv);
    logic        m;
    logic [15:0] cap;
    logic [15:0] expm;
    tx_data = txv;
    NSS = 1'b0;
    clk_n(8);
    chk({tag, "_open"}, frame_active, 1'b1);
    mdl_cnt = 0;
    for (int w = 0; w < nw; w++) begin
      fifo_full = f_arr[w];
      cap = 16'h0000;
      for (int b = 15; b >= 0; b--) begin
        send_bit(w_arr[w][b], m);
        cap[b] = m;
      end
`ifdef SPI_SLAVE_ECHO_EN
      expm = (w == 0) ? 16'h0000 : w_arr[w-1];
`else
      expm = txv;
`endif
      chk({tag, "_miso_word"}, cap, expm);
      if (mdl_cnt < 65535) mdl_cnt++;
      if (f_arr[w]) mdl_ovf = 1'b1;
      else exp_q.push_back(w_arr[w]);
    end
    fifo_full = 1'b0;
    for (int b = 0; b < part; b++) begin
      send_bit(w_arr[nw][15-b], m);
    end
    if (part > 0) mdl_ferr = 1'b1;
    clk_n(8);
    NSS = 1'b1;
    clk_n(10);
    check_status(tag);
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1;
    clk_n(1);
    err_clr = 1'b0;
    mdl_ovf  = 1'b0;
    mdl_ferr = 1'b0;
    clk_n(2);
    chk("clr_ovf", overflow_err, 1'b0);
    chk("clr_ferr", frame_err, 1'b0);
  endtask

  initial begin
    logic m;
    int   nw;
    int   part;
    sys_rst   = 1'b1;
    SCK       = 1'b0;
    MOSI      = 1'b0;
    NSS       = 1'b1;
    fifo_full = 1'b0;
    tx_data   = 16'h0000;
    err_clr   = 1'b0;
    mdl_cnt   = 0;
    mdl_ovf   = 1'b0;
    mdl_ferr  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_arr[i] = 16'h0000;
      f_arr[i] = 1'b0;
    end
    clk_n(3);
    chk("rst_miso", MISO, 1'b0);
    chk("rst_wr_req", fifo_wr_req, 1'b0);
    chk("rst_wr_data", fifo_wr_data, 16'h0000);
    chk("rst_active", frame_active, 1'b0);
    chk("rst_word_cnt", word_cnt, 16'h0000);
    chk("rst_ovf", overflow_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    sys_rst = 1'b0;
    clk_n(6);

    // Two-word frame
    w_arr[0] = 16'hA5C3; w_arr[1] = 16'h0F0F;
    run_frame("two_words", 2, 0, 16'h1234);

    // Status word returned on MISO
    w_arr[0] = 16'h3C5A;
    run_frame("status", 1, 0, 16'h8001);

    // Three words (echo build returns the previous word)
    w_arr[0] = 16'h1234; w_arr[1] = 16'h5678; w_arr[2] = 16'h9ABC;
    run_frame("three", 3, 0, 16'h0000);

    // Overflow on the middle word, then clear
    w_arr[0] = 16'h1111; w_arr[1] = 16'h2222; w_arr[2] = 16'h3333;
    f_arr[1] = 1'b1;
    run_frame("overflow", 3, 0, 16'hC3C3);
    f_arr[1] = 1'b0;
    pulse_clear();

    // NSS rises after 9 bits, then a clean frame keeps frame_err set
    w_arr[0] = 16'h5AA5;
    run_frame("partial", 0, 9, 16'h0001);
    w_arr[0] = 16'hBEEF;
    run_frame("after_partial", 1, 0, 16'h7E7E);
    pulse_clear();

    // Reset after 8 bits of a word
    NSS = 1'b0;
    clk_n(8);
    for (int b = 0; b < 8; b++) send_bit(b[0], m);
    sys_rst = 1'b1;
    #1;
    chk("midrst_active", frame_active, 1'b0);
    chk("midrst_miso", MISO, 1'b0);
    chk("midrst_word_cnt", word_cnt, 16'h0000);
    chk("midrst_wr_req", fifo_wr_req, 1'b0);
    clk_n(3);
    sys_rst = 1'b0;
    // NSS still low: SCK activity must be ignored until a fresh fall
    for (int b = 0; b < 8; b++) send_bit(1'b1, m);
    chk("midrst_no_frame", frame_active, 1'b0);
    NSS = 1'b1;
    clk_n(10);
    mdl_cnt = 0;
    check_status("midrst");
    w_arr[0] = 16'h00FF;
    run_frame("post_rst", 1, 0, 16'hA0A0);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) pulse_clear();
      nw   = $urandom_range(1, 4);
      part = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 0;
      for (int i = 0; i < 8; i++) begin
        w_arr[i] = 16'($urandom);
        f_arr[i] = ($urandom_range(0, 3) == 0);
      end
      run_frame("rand", nw, part, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
